// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: LEGv8 multi-cycle control FSM; define ILLEGAL_TRAP_EN to trap illegal opcodes in HALT.
module multicycle_ctrl #(
    parameter int OP_W = 11
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [OP_W-1:0] i_opcode,
    input  logic            i_zero,
    input  logic            i_mem_ready,
    output logic [1:0]      o_alu_ctrl,
    output logic            o_alu_src_a,
    output logic [1:0]      o_alu_src_b,
    output logic [1:0]      o_result_src,
    output logic            o_adr_src,
    output logic            o_mem_read,
    output logic            o_mem_write,
    output logic            o_ir_write,
    output logic            o_pc_write,
    output logic            o_reg_write,
    output logic            o_instr_done,
    output logic            o_illegal
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, ALUWB, CBZ, BRANCH, HALT
    } state_t;

    state_t state;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
    assign o_illegal = !i_reset && state == HALT;
`else
    localparam bit TRAP = 1'b0;
    assign o_illegal = 1'b0;
`endif

    localparam state_t ILL_NEXT = TRAP ? HALT : FETCH;

    logic is_add, is_sub, is_and, is_orr, is_ldur, is_stur, is_cbz, is_b;
    logic is_r, is_mem, is_legal;

    assign is_add   = i_opcode == 11'b10001011000;
    assign is_sub   = i_opcode == 11'b11001011000;
    assign is_and   = i_opcode == 11'b10001010000;
    assign is_orr   = i_opcode == 11'b10101010000;
    assign is_ldur  = i_opcode == 11'b11111000010;
    assign is_stur  = i_opcode == 11'b11111000000;
    assign is_cbz   = i_opcode[OP_W-1 -: 8] == 8'b10110100;
    assign is_b     = i_opcode[OP_W-1 -: 6] == 6'b000101;
    assign is_r     = is_add | is_sub | is_and | is_orr;
    assign is_mem   = is_ldur | is_stur;
    assign is_legal = is_r | is_mem | is_cbz | is_b;

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= FETCH;
        else begin
            case (state)
                FETCH:    state <= i_mem_ready ? DECODE : FETCH;
                DECODE:   state <= is_mem ? MEMADR : is_r ? EXEC_R : is_cbz ? CBZ : is_b ? BRANCH : ILL_NEXT;
                MEMADR:   state <= is_ldur ? MEMREAD : MEMWRITE;
                MEMREAD:  state <= i_mem_ready ? MEMWB : MEMREAD;
                MEMWRITE: state <= i_mem_ready ? FETCH : MEMWRITE;
                EXEC_R:   state <= ALUWB;
                HALT:     state <= HALT;
                default:  state <= FETCH;
            endcase
        end
    end

    always_comb begin
        o_alu_ctrl   = 2'b00;
        o_alu_src_a  = 1'b0;
        o_alu_src_b  = 2'b00;
        o_result_src = 2'b00;
        o_adr_src    = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_ir_write   = 1'b0;
        o_pc_write   = 1'b0;
        o_reg_write  = 1'b0;
        o_instr_done = 1'b0;
        case (state)
            FETCH: begin
                o_mem_read   = 1'b1;
                o_alu_src_b  = 2'b01;
                o_result_src = 2'b10;
                o_ir_write   = i_mem_ready;
                o_pc_write   = i_mem_ready;
            end
            DECODE: begin
                o_alu_src_b  = 2'b11;
                o_instr_done = !is_legal && !TRAP;
            end
            MEMADR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b10;
            end
            MEMREAD: begin
                o_adr_src  = 1'b1;
                o_mem_read = 1'b1;
            end
            MEMWB: begin
                o_result_src = 2'b01;
                o_reg_write  = 1'b1;
                o_instr_done = 1'b1;
            end
            MEMWRITE: begin
                o_adr_src    = 1'b1;
                o_mem_write  = 1'b1;
                o_instr_done = i_mem_ready;
            end
            EXEC_R: begin
                o_alu_src_a = 1'b1;
                o_alu_ctrl  = is_sub ? 2'b01 : is_and ? 2'b10 : is_orr ? 2'b11 : 2'b00;
            end
            ALUWB: begin
                o_reg_write  = 1'b1;
                o_instr_done = 1'b1;
            end
            CBZ: begin
                o_pc_write   = i_zero;
                o_instr_done = 1'b1;
            end
            BRANCH: begin
                o_pc_write   = 1'b1;
                o_instr_done = 1'b1;
            end
            default: ;
        endcase
        if (i_reset) begin
            o_alu_ctrl   = 2'b00;
            o_alu_src_a  = 1'b0;
            o_alu_src_b  = 2'b00;
            o_result_src = 2'b00;
            o_adr_src    = 1'b0;
            o_mem_read   = 1'b0;
            o_mem_write  = 1'b0;
            o_ir_write   = 1'b0;
            o_pc_write   = 1'b0;
            o_reg_write  = 1'b0;
            o_instr_done = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed bench for the LEGv8 multi-cycle control FSM.
module tb_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        reset, zero, ready;
    logic [10:0] opcode;
    logic [1:0]  alu_ctrl, alu_src_b, result_src;
    logic        alu_src_a, adr_src, mem_read, mem_write, ir_write, pc_write, reg_write, instr_done, illegal;
    logic [14:0] obs;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .i_clk(clk), .i_reset(reset), .i_opcode(opcode), .i_zero(zero), .i_mem_ready(ready),
        .o_alu_ctrl(alu_ctrl), .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b),
        .o_result_src(result_src), .o_adr_src(adr_src), .o_mem_read(mem_read),
        .o_mem_write(mem_write), .o_ir_write(ir_write), .o_pc_write(pc_write),
        .o_reg_write(reg_write), .o_instr_done(instr_done), .o_illegal(illegal)
    );

    // {alu_ctrl, src_a, src_b, result_src, adr_src, mem_read, mem_write, ir_write, pc_write, reg_write, instr_done, illegal}
    assign obs = {alu_ctrl, alu_src_a, alu_src_b, result_src, adr_src, mem_read, mem_write,
                  ir_write, pc_write, reg_write, instr_done, illegal};

    localparam logic [14:0] ZERO    = 15'd0;
    localparam logic [14:0] F_RDY   = {2'b00, 1'b0, 2'b01, 2'b10, 8'b01011000};
    localparam logic [14:0] F_WAIT  = {2'b00, 1'b0, 2'b01, 2'b10, 8'b01000000};
    localparam logic [14:0] DEC     = {2'b00, 1'b0, 2'b11, 2'b00, 8'b00000000};
    localparam logic [14:0] DEC_NOP = {2'b00, 1'b0, 2'b11, 2'b00, 8'b00000010};
    localparam logic [14:0] MADR    = {2'b00, 1'b1, 2'b10, 2'b00, 8'b00000000};
    localparam logic [14:0] MRD     = {2'b00, 1'b0, 2'b00, 2'b00, 8'b11000000};
    localparam logic [14:0] MWB     = {2'b00, 1'b0, 2'b00, 2'b01, 8'b00000110};
    localparam logic [14:0] MW_WAIT = {2'b00, 1'b0, 2'b00, 2'b00, 8'b10100000};
    localparam logic [14:0] MW_DONE = {2'b00, 1'b0, 2'b00, 2'b00, 8'b10100010};
    localparam logic [14:0] AWB     = {2'b00, 1'b0, 2'b00, 2'b00, 8'b00000110};
    localparam logic [14:0] CBZ_NT  = {2'b00, 1'b0, 2'b00, 2'b00, 8'b00000010};
    localparam logic [14:0] PC_DONE = {2'b00, 1'b0, 2'b00, 2'b00, 8'b00001010};
    localparam logic [14:0] HALT_V  = 15'd1;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_B    = 11'b00010110011;
    localparam logic [10:0] OP_ILL  = 11'b11111111111;

    function automatic logic [14:0] exec_vec(input logic [1:0] a);
        return {a, 1'b1, 2'b00, 2'b00, 8'b00000000};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [14:0] exp [0:2];
        reset = 1'b1; ready = 1'b1; zero = 1'b0; opcode = OP_B;
        tick();
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (obs !== ZERO) begin
                errors++;
                $display("FAIL reset cycle %0d: got %h expected %h", i, obs, ZERO);
            end
            tick();
        end
        reset = 1'b0;
        exp = '{F_RDY, DEC, PC_DONE};
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL reset_then_b cycle %0d: got %h expected %h", i, obs, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_rtype;
        logic [10:0] ops [0:3];
        logic [14:0] exp [0:3];
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_ORR};
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            opcode = ops[k];
            exp = '{F_RDY, DEC, exec_vec(2'(k)), AWB};
            for (int i = 0; i < 4; i++) begin
                #1;
                checks++;
                if (obs !== exp[i]) begin
                    errors++;
                    $display("FAIL rtype op%0d cycle %0d: got %h expected %h", k, i, obs, exp[i]);
                end
                tick();
            end
        end
    endtask

    task automatic test_ldur_wait;
        logic [14:0] exp [0:7];
        logic [7:0]  rdy;
        exp = '{F_RDY, DEC, MADR, MRD, MRD, MRD, MRD, MWB};
        rdy = 8'b1100_0111;
        opcode = OP_LDUR;
        for (int i = 0; i < 8; i++) begin
            ready = rdy[i];
            #1;
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL ldur_wait cycle %0d: got %h expected %h", i, obs, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_stur_wait;
        logic [14:0] exp [0:5];
        logic [5:0]  rdy;
        exp = '{F_WAIT, F_RDY, DEC, MADR, MW_WAIT, MW_DONE};
        rdy = 6'b101110;
        opcode = OP_STUR;
        for (int i = 0; i < 6; i++) begin
            ready = rdy[i];
            #1;
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL stur_wait cycle %0d: got %h expected %h", i, obs, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_cbz;
        logic [14:0] exp [0:2];
        ready = 1'b1;
        opcode = OP_CBZ;
        for (int z = 0; z < 2; z++) begin
            zero = z[0];
            exp = '{F_RDY, DEC, (z == 1) ? PC_DONE : CBZ_NT};
            for (int i = 0; i < 3; i++) begin
                #1;
                checks++;
                if (obs !== exp[i]) begin
                    errors++;
                    $display("FAIL cbz z=%0d cycle %0d: got %h expected %h", z, i, obs, exp[i]);
                end
                tick();
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_illegal;
`ifdef ILLEGAL_TRAP_EN
        logic [14:0] exp [0:6];
        logic [6:0]  rdy, rst;
        int          n = 7;
        exp = '{F_RDY, DEC, HALT_V, HALT_V, HALT_V, ZERO, F_WAIT};
        rdy = 7'b0111111;
        rst = 7'b0100000;
`else
        logic [14:0] exp [0:2];
        logic [2:0]  rdy, rst;
        int          n = 3;
        exp = '{F_RDY, DEC_NOP, F_WAIT};
        rdy = 3'b011;
        rst = 3'b000;
`endif
        opcode = OP_ILL;
        for (int i = 0; i < n; i++) begin
            ready = rdy[i];
            reset = rst[i];
            #1;
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL illegal cycle %0d: got %h expected %h", i, obs, exp[i]);
            end
            tick();
        end
        reset = 1'b0;
    endtask

    task automatic test_reset_memwrite;
        logic [14:0] exp [0:5];
        logic [5:0]  rdy, rst;
        exp = '{F_RDY, DEC, MADR, MW_WAIT, ZERO, F_WAIT};
        rdy = 6'b000111;
        rst = 6'b010000;
        opcode = OP_STUR;
        for (int i = 0; i < 6; i++) begin
            ready = rdy[i];
            reset = rst[i];
            #1;
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL reset_memwrite cycle %0d: got %h expected %h", i, obs, exp[i]);
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_ldur_wait();
        test_stur_wait();
        test_cbz();
        test_illegal();
        test_reset_memwrite();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
